// File: rtl/uart_tx_fsm.sv
// 8N1 UART transmitter. Bytes come in over valid/ready into a one-entry holding
// register and are shifted out LSB first, with back-to-back frames when one is queued.
module uart_tx_fsm #(
  parameter int CLK_HZ      = 65_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int CLK_PER_BIT = 6768,
  parameter int PKT_LEN     = 8,
  parameter int STOP_BITS   = 1
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [PKT_LEN-1:0] data_in,
  input  logic               valid_in,
  output logic               ready_out,
  output logic               sig_out,
  output logic               busy_out
);

  localparam int CNT_W = $clog2(STOP_BITS * CLK_PER_BIT);
  localparam int BIT_W = $clog2(PKT_LEN + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLK_PER_BIT - 1);
  localparam logic [BIT_W-1:0] PKT_LAST  = BIT_W'(PKT_LEN - 1);

  generate
    if (CLK_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        PKT_LEN < 1 || CLK_HZ <= 0 || BAUD_RATE <= 0) begin : g_bad_params
      $error("uart_tx_fsm: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [PKT_LEN-1:0] shift_q, shift_d;
  logic [PKT_LEN-1:0] hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic               sig_q, sig_d;
  logic               accept_s;
  logic               load_s;

  assign ready_out = ~hold_full_q & ~rst_in;
  assign accept_s  = valid_in & ready_out;
  assign sig_out   = sig_q;
  assign busy_out  = (state_q != S_IDLE);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sig_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sig_q       <= sig_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    load_s      = 1'b0;

    case (state_q)
      S_IDLE: begin
        load_s = hold_full_q;
      end
      S_START: begin
        if (cnt_q == BIT_LAST) begin
          state_d = S_DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == PKT_LAST) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == STOP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          load_s  = hold_full_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase

    // Transfer from the holding register; an accept can never coincide since ready needs it empty.
    if (load_s) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      cnt_d       = '0;
      bit_d       = '0;
      state_d     = S_START;
    end else if (accept_s) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end else begin
      hold_d      = hold_q;
    end

    case (state_q)
      S_START: sig_d = 1'b0;
      S_DATA:  sig_d = shift_q[0];
      default: sig_d = 1'b1;
    endcase
  end

endmodule

// File: doc/uart_tx_fsm.md
Name: uart_tx_fsm

Overview:
- UART transmitter: serialises bytes onto a single line as 8N1 frames (idle high, one start bit low, 8 data bits LSB first, stop bit(s) high).
- It is the transmit counterpart of the team's UART receiver and uses the same clock and bit timing, so its output can loop straight into the receiver.
- Upstream logic hands it bytes over a valid/ready handshake.
- A one-entry holding register lets the next byte be queued while the current frame is still shifting out.

Parameters:
- CLK_HZ, 65_000_000, system clock frequency in Hz (documentation only).
- BAUD_RATE, 9600, line rate (documentation only).
- CLK_PER_BIT, 6768, clock cycles per bit; must match the receiver's 16 samples × 423 clocks. Legal range ≥ 2.
- PKT_LEN, 8, data bits per frame.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
- clk_in  input  1  system clock, all logic on rising edge.
- rst_in  input  1  asynchronous active-high reset.
- data_in  input  PKT_LEN  byte to send; sampled only on an accepted handshake.
- valid_in  input  1  upstream has a byte on data_in.
- ready_out  output  1  holding register empty, so a byte can be accepted.
- sig_out  output  1  serial line, registered, idle high.
- busy_out  output  1  a frame is in progress (state is not IDLE).

Behaviour:
- Reset (async assert, sync release):
  - sig_out=1, busy_out=0, ready_out=0 while rst_in is high.
  - Holding register empty; state IDLE; bit and cycle counters 0.
  - Reset asserted mid-frame drives sig_out high immediately and discards both the in-flight byte and the queued byte.
- Handshake:
  - ready_out = ~hold_full && ~rst_in.
  - A byte is accepted on a rising edge where valid_in && ready_out; data_in is latched into the holding register and hold_full is set.
  - While hold_full=1, ready_out=0 and valid_in is ignored. The register does not accept a byte on the same edge it drains.
- State machine:
  - IDLE: sig_out=1. When hold_full, move the holding register into the shift register, clear hold_full, load the cycle counter with 0, and go to START.
  - START: sig_out=0 for CLK_PER_BIT cycles, then go to DATA with the bit index at 0.
  - DATA: sig_out = shift[0] for CLK_PER_BIT cycles, then shift right and increment the bit index. After PKT_LEN bits, go to STOP.
  - STOP: sig_out=1 for STOP_BITS × CLK_PER_BIT cycles. At the end:
    - if hold_full, do the IDLE transfer action and go directly to START (back-to-back frames, no idle gap);
    - otherwise go to IDLE.
- Timing:
  - A byte accepted at edge k into an empty, IDLE block is transferred at edge k+1.
  - sig_out falls on edge k+2; sig_out is registered and lags the state by one cycle.
  - The frame lasts exactly (1 + PKT_LEN + STOP_BITS) × CLK_PER_BIT cycles. Every bit cell is exactly CLK_PER_BIT cycles long, with no ±1 drift.
- Counters:
  - The cycle counter is wide enough for STOP_BITS × CLK_PER_BIT − 1.
  - It counts from 0 and the terminal compare is CLK_PER_BIT − 1; it does not wrap.
  - The bit index is $clog2(PKT_LEN+1) bits wide.
- Other state encodings recover to IDLE on the next clock with sig_out=1.
- busy_out is high from the transfer edge through the last stop-bit cycle.

Test Plan:
- Reset: with CLK_PER_BIT=16, assert rst_in mid-cycle -> sig_out=1, ready_out=0, busy_out=0 immediately. After release, ready_out=1 and the line stays high for 500 cycles with no input.
- Single byte: send 0xA5 -> sig_out sequence start 0, then 1,0,1,0,0,1,0,1, then stop 1, each bit exactly 16 cycles. The first falling edge is 2 cycles after acceptance; busy_out stays high for 160 cycles.
- Back-to-back: send 0x00, then 0xFF as soon as ready_out returns high -> the 0xFF start bit begins the cycle after the 0x00 stop bit ends, with no idle cycles. ready_out is high again after 0xFF is transferred.
- Backpressure: hold valid_in high with three bytes 0x11, 0x22, 0x33 -> 0x11 and 0x22 are accepted at once. 0x33 stalls (ready_out=0) until the 0x11 frame ends and 0x22 transfers. All three frames appear in order.
- Reset mid-frame: assert rst_in during data bit 3 of 0x5A with 0xC3 queued -> line high, both bytes lost. After release, sending 0x3C transmits only 0x3C, correctly framed.
- Loopback: CLK_PER_BIT=6768; feed sig_out into the team's UART receiver after its arming idle period; send 0x00, 0x55, 0xAA, 0xFF -> the receiver's data output matches each byte.
